// File: rtl/rca_input_dispatch_if.sv
// Bundle between the RCA issue controller, the input dispatcher and the grid input units.
// The master drives operands, table writes and grid pops; the slave (dispatcher) drives FIFO heads.
interface rca_input_dispatch_if #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_READ_PORTS = 5,
    parameter int unsigned NUM_RCAS       = 4
);
    localparam int unsigned RcaW = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;

    logic                                     buf_data_valid;
    logic                                     clear_fifos;
    logic [RcaW-1:0]                          rca_sel_buf;
    logic [NUM_READ_PORTS-1:0][XLEN-1:0]      buf_rs_data;
    logic                                     cfg_we;
    logic [RcaW-1:0]                          cfg_rca;
    logic [NUM_READ_PORTS-1:0]                cfg_mask;
    logic [NUM_READ_PORTS-1:0]                grid_pop;
    logic [NUM_READ_PORTS-1:0][XLEN-1:0]      grid_data;
    logic [NUM_READ_PORTS-1:0]                grid_valid;
    logic                                     dispatch_stall;
    logic                                     overflow_err;

    modport master (
        output buf_data_valid, clear_fifos, rca_sel_buf, buf_rs_data,
               cfg_we, cfg_rca, cfg_mask, grid_pop,
        input  grid_data, grid_valid, dispatch_stall, overflow_err
    );

    modport slave (
        input  buf_data_valid, clear_fifos, rca_sel_buf, buf_rs_data,
               cfg_we, cfg_rca, cfg_mask, grid_pop,
        output grid_data, grid_valid, dispatch_stall, overflow_err
    );
endinterface

// File: rtl/rca_input_dispatch.sv
// Pushes buffered read-port operands into per-port FIFOs feeding the RCA grid input units,
// gated by a per-RCA port-enable table; all FIFOs flush on an accelerator switch.
module rca_input_dispatch #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_READ_PORTS = 5,
    parameter int unsigned NUM_RCAS       = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    rca_input_dispatch_if.slave   bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Depth    = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] StallLvl = CntW'(FIFO_DEPTH - 1);

    logic [NUM_READ_PORTS-1:0] r_table [NUM_RCAS];
    logic [XLEN-1:0]           r_mem   [NUM_READ_PORTS][FIFO_DEPTH];
    logic [PtrW-1:0]           r_wptr  [NUM_READ_PORTS];
    logic [PtrW-1:0]           r_rptr  [NUM_READ_PORTS];
    logic [CntW-1:0]           r_count [NUM_READ_PORTS];
    logic                      r_overflow;

    logic [NUM_READ_PORTS-1:0] w_mask;
    logic [NUM_READ_PORTS-1:0] w_push;
    logic [NUM_READ_PORTS-1:0] w_pop;
    logic [NUM_READ_PORTS-1:0] w_accept;
    logic [NUM_READ_PORTS-1:0] w_drop;
    logic [PtrW-1:0]           w_waddr [NUM_READ_PORTS];

    // Mask is read before any same-cycle table write lands, so a push uses the old entry.
    assign w_mask = r_table[bus.rca_sel_buf];

    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            w_push[p]   = bus.buf_data_valid & w_mask[p];
            w_pop[p]    = bus.grid_pop[p] & (r_count[p] != '0) & ~bus.clear_fifos;
            // After a clear the FIFO is empty, so the push always lands in slot 0.
            w_accept[p] = w_push[p] & (bus.clear_fifos | (r_count[p] != Depth) | w_pop[p]);
            w_drop[p]   = w_push[p] & ~w_accept[p];
            w_waddr[p]  = bus.clear_fifos ? '0 : r_wptr[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_RCAS; r++) begin
                r_table[r] <= '1;
            end
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                r_wptr[p]  <= '0;
                r_rptr[p]  <= '0;
                r_count[p] <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            if (bus.cfg_we) begin
                r_table[bus.cfg_rca] <= bus.cfg_mask;
            end
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                if (bus.clear_fifos) begin
                    r_rptr[p]  <= '0;
                    r_wptr[p]  <= w_accept[p] ? PtrW'(1) : '0;
                    r_count[p] <= w_accept[p] ? CntW'(1) : '0;
                end else begin
                    if (w_accept[p]) begin
                        r_wptr[p] <= r_wptr[p] + PtrW'(1);
                    end
                    if (w_pop[p]) begin
                        r_rptr[p] <= r_rptr[p] + PtrW'(1);
                    end
                    r_count[p] <= r_count[p] + CntW'(w_accept[p]) - CntW'(w_pop[p]);
                end
            end
        end
    end

    // Storage carries no reset; contents are only observable while the count is non-zero.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (!rst && w_accept[p]) begin
                r_mem[p][w_waddr[p]] <= bus.buf_rs_data[p];
            end
        end
    end

    always_comb begin
        bus.dispatch_stall = 1'b0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            bus.grid_data[p]  = r_mem[p][r_rptr[p]];
            bus.grid_valid[p] = (r_count[p] != '0);
            if (w_mask[p] && (r_count[p] >= StallLvl)) begin
                bus.dispatch_stall = 1'b1;
            end
        end
        bus.overflow_err = r_overflow;
    end
endmodule

// File: tb/tb_rca_input_dispatch.sv
// Bench for rca_input_dispatch: directed scenarios plus random traffic, checked by a
// negedge monitor against per-port reference queues updated at every clock edge.
module tb_rca_input_dispatch;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NP   = 5;
    localparam int unsigned NR   = 4;
    localparam int unsigned D    = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    bit   mon_en;

    rca_input_dispatch_if #(.XLEN(XLEN), .NUM_READ_PORTS(NP), .NUM_RCAS(NR)) bus ();

    rca_input_dispatch #(
        .XLEN          (XLEN),
        .NUM_READ_PORTS(NP),
        .NUM_RCAS      (NR),
        .FIFO_DEPTH    (D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: one queue of expected operands per port, the table, sticky error.
    logic [XLEN-1:0] mq [NP][$];
    logic [NP-1:0]   mtbl [NR];
    bit              movf;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [NP-1:0] mask;
        if (rst) begin
            for (int p = 0; p < NP; p++) mq[p].delete();
            for (int r = 0; r < NR; r++) mtbl[r] = '1;
            movf = 1'b0;
            return;
        end
        mask = mtbl[bus.rca_sel_buf];
        if (bus.cfg_we) mtbl[bus.cfg_rca] = bus.cfg_mask;
        for (int p = 0; p < NP; p++) begin
            if (bus.clear_fifos) begin
                mq[p].delete();
                if (bus.buf_data_valid && mask[p]) mq[p].push_back(bus.buf_rs_data[p]);
            end else begin
                if (bus.grid_pop[p] && mq[p].size() > 0) void'(mq[p].pop_front());
                if (bus.buf_data_valid && mask[p]) begin
                    if (mq[p].size() < D) mq[p].push_back(bus.buf_rs_data[p]);
                    else movf = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        bus.buf_data_valid = 1'b0;
        bus.clear_fifos    = 1'b0;
        bus.cfg_we         = 1'b0;
        bus.grid_pop       = '0;
    endtask

    task automatic load(input int sel, input logic [XLEN-1:0] base);
        bus.rca_sel_buf    = 2'(sel);
        bus.buf_data_valid = 1'b1;
        for (int p = 0; p < NP; p++) bus.buf_rs_data[p] = base + XLEN'(p);
    endtask

    always @(negedge clk) begin
        logic [NP-1:0] ev;
        logic [NP-1:0] m;
        logic          es;
        if (mon_en) begin
            m  = mtbl[bus.rca_sel_buf];
            es = 1'b0;
            for (int p = 0; p < NP; p++) begin
                ev[p] = (mq[p].size() != 0);
                if (m[p] && mq[p].size() >= D - 1) es = 1'b1;
            end
            check("mon_grid_valid", 64'(bus.grid_valid), 64'(ev));
            for (int p = 0; p < NP; p++) begin
                if (ev[p]) check($sformatf("mon_grid_data[%0d]", p),
                                 64'(bus.grid_data[p]), 64'(mq[p][0]));
            end
            check("mon_dispatch_stall", 64'(bus.dispatch_stall), 64'(es));
            check("mon_overflow_err", 64'(bus.overflow_err), 64'(movf));
        end
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        set_idle();
        bus.rca_sel_buf = '0;
        bus.cfg_rca     = '0;
        bus.cfg_mask    = '0;
        bus.buf_rs_data = '0;
        step();
        step();
        mon_en = 1'b1;
        rst    = 1'b0;
        check("reset_valid", 64'(bus.grid_valid), 64'h0);
        check("reset_ovf", 64'(bus.overflow_err), 64'h0);
        check("reset_stall", 64'(bus.dispatch_stall), 64'h0);

        // Default mask pushes every port.
        load(0, 1);
        step();
        set_idle();
        check("first_push_valid", 64'(bus.grid_valid), 64'h1f);
        for (int p = 0; p < NP; p++)
            check("first_push_data", 64'(bus.grid_data[p]), 64'(p + 1));
        bus.grid_pop = '1;
        step();
        set_idle();

        // Narrow mask on RCA 2.
        bus.cfg_we = 1'b1; bus.cfg_rca = 2'd2; bus.cfg_mask = 5'b00011;
        step();
        set_idle();
        for (int k = 0; k < 3; k++) begin
            load(2, 32'(10 * (k + 1)));
            step();
            set_idle();
        end
        check("mask2_valid", 64'(bus.grid_valid), 64'h03);
        check("mask2_stall", 64'(bus.dispatch_stall), 64'h1);
        bus.grid_pop = '1;
        repeat (3) step();
        set_idle();

        // Port 0 only: fill, push+pop while full, then overflow.
        bus.cfg_we = 1'b1; bus.cfg_rca = 2'd1; bus.cfg_mask = 5'b00001;
        step();
        set_idle();
        for (int k = 1; k <= 4; k++) begin
            load(1, 32'(k));
            step();
            set_idle();
        end
        load(1, 9);
        bus.grid_pop = 5'b00001;
        step();
        set_idle();
        check("full_pushpop_ovf", 64'(bus.overflow_err), 64'h0);
        check("full_pushpop_head", 64'(bus.grid_data[0]), 64'd2);
        load(1, 77);
        step();
        set_idle();
        check("overflow_set", 64'(bus.overflow_err), 64'h1);
        for (int k = 0; k < 4; k++) begin
            check("drain_order", 64'(bus.grid_data[0]), (k == 3) ? 64'd9 : 64'(k + 2));
            bus.grid_pop = 5'b00001;
            step();
            set_idle();
        end
        check("drain_empty", 64'(bus.grid_valid), 64'h0);
        check("overflow_sticky", 64'(bus.overflow_err), 64'h1);

        // Reset, then clear coinciding with push and pop.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_ovf_clear", 64'(bus.overflow_err), 64'h0);
        load(0, 32'h20); step();
        load(0, 32'h30); step();
        load(0, 32'hA0);
        bus.clear_fifos = 1'b1;
        bus.grid_pop    = '1;
        step();
        set_idle();
        check("clear_push_valid", 64'(bus.grid_valid), 64'h1f);
        for (int p = 0; p < NP; p++)
            check("clear_push_data", 64'(bus.grid_data[p]), 64'(32'hA0 + p));

        // Empty pop is harmless; reset mid-stream restores the table.
        bus.grid_pop = '1;
        step();
        step();
        set_idle();
        check("empty_pop_valid", 64'(bus.grid_valid), 64'h0);
        load(2, 32'h50); step();
        load(2, 32'h60);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_idle();
        check("midrst_valid", 64'(bus.grid_valid), 64'h0);
        check("midrst_ovf", 64'(bus.overflow_err), 64'h0);
        load(2, 32'h70);
        step();
        set_idle();
        check("table_reset_all_ones", 64'(bus.grid_valid), 64'h1f);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.buf_data_valid = ($urandom_range(0, 9) < 6);
            bus.rca_sel_buf    = 2'($urandom_range(0, NR - 1));
            for (int p = 0; p < NP; p++) bus.buf_rs_data[p] = $urandom;
            bus.grid_pop       = 5'($urandom_range(0, 31));
            bus.clear_fifos    = ($urandom_range(0, 19) == 0);
            bus.cfg_we         = ($urandom_range(0, 14) == 0);
            bus.cfg_rca        = 2'($urandom_range(0, NR - 1));
            bus.cfg_mask       = 5'($urandom_range(0, 31));
            rst                = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        set_idle();
        step();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
